// File: rtl/fifo_prog.sv
// Single-clock FIFO with optional first-word-fall-through output, programmable
// almost-full/almost-empty thresholds, fill level and sticky overflow/underflow flags.
module fifo_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int FWFT       = 0,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [AW:0]           level,
  input  logic [AW:0]           afull_thresh,
  input  logic [AW:0]           aempty_thresh,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           level_q;

  logic                  full_c;
  logic                  empty_c;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  mem_we;
  logic                  mem_re;
  logic                  dout_load;
  logic [DATA_WIDTH-1:0] dout_next;
  logic                  valid_next;

  assign full_c = (level_q == FULL_LEVEL);
  assign wr_acc = wr_en && !full_c;
  assign rd_acc = rd_en && !empty_c;

  generate
    if (FWFT != 0) begin : g_fwft
      // dout is the head register; memory holds only the words queued behind it.
      logic [AW:0] mem_cnt;
      logic        need_head;
      logic        bypass;

      assign empty_c = !dout_valid;

      always_comb begin
        mem_cnt    = level_q - {{AW{1'b0}}, dout_valid};
        need_head  = !dout_valid || rd_acc;
        mem_re     = need_head && (mem_cnt != '0);
        bypass     = need_head && (mem_cnt == '0) && wr_acc;
        mem_we     = wr_acc && !bypass;
        dout_load  = mem_re || bypass;
        dout_next  = mem_re ? mem[rd_ptr] : din;
        valid_next = mem_re || bypass || (dout_valid && !rd_acc);
      end
    end else begin : g_std
      assign empty_c = (level_q == '0);

      always_comb begin
        mem_re     = rd_acc;
        mem_we     = wr_acc;
        dout_load  = rd_acc;
        dout_next  = mem[rd_ptr];
        valid_next = rd_acc;
      end
    end
  endgenerate

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (mem_we)
        wr_ptr <= wr_ptr + AW'(1);
      if (mem_re)
        rd_ptr <= rd_ptr + AW'(1);

      case ({wr_acc, rd_acc})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase

      if (dout_load)
        dout <= dout_next;
      dout_valid <= valid_next;

      // A new error event wins over a clear arriving in the same cycle.
      if (wr_en && full_c)
        overflow <= 1'b1;
      else if (clr_err)
        overflow <= 1'b0;

      if (rd_en && empty_c)
        underflow <= 1'b1;
      else if (clr_err)
        underflow <= 1'b0;
    end
  end

  assign full         = full_c;
  assign empty        = empty_c;
  assign level        = level_q;
  assign almost_full  = (level_q >= afull_thresh);
  assign almost_empty = (level_q <= aempty_thresh);

endmodule

// File: tb/tb_fifo_prog.sv
// Directed bench for fifo_prog: a standard-mode and an FWFT instance share one
// stimulus stream, each checked against its own queue-based scoreboard.
module tb_fifo_prog;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic          rd_en;
  logic          clr_err;
  logic [DW-1:0] din;
  logic [AW:0]   afull_thresh;
  logic [AW:0]   aempty_thresh;

  logic [DW-1:0] s_dout, f_dout;
  logic          s_dv, f_dv, s_full, f_full, s_empty, f_empty;
  logic          s_af, f_af, s_ae, f_ae, s_ovf, f_ovf, s_unf, f_unf;
  logic [AW:0]   s_level, f_level;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] sq[$];
  logic [DW-1:0] fq[$];
  logic [DW-1:0] s_dout_exp;
  bit            s_dv_exp;
  bit            s_ovf_exp, s_unf_exp, f_ovf_exp, f_unf_exp;

  always #5 clk = ~clk;

  fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(s_dout), .dout_valid(s_dv), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .level(s_level),
    .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh),
    .overflow(s_ovf), .underflow(s_unf), .clr_err(clr_err)
  );

  fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(f_dout), .dout_valid(f_dv), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .level(f_level),
    .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh),
    .overflow(f_ovf), .underflow(f_unf), .clr_err(clr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    int sn, fn;
    sn = sq.size();
    fn = fq.size();
    check("std_level", 32'(s_level), 32'(sn));
    check("std_full",  32'(s_full),  32'(sn == DEPTH));
    check("std_empty", 32'(s_empty), 32'(sn == 0));
    check("std_afull", 32'(s_af),    32'(sn >= int'(afull_thresh)));
    check("std_aempty",32'(s_ae),    32'(sn <= int'(aempty_thresh)));
    check("std_ovf",   32'(s_ovf),   32'(s_ovf_exp));
    check("std_unf",   32'(s_unf),   32'(s_unf_exp));
    check("std_dvalid",32'(s_dv),    32'(s_dv_exp));
    check("std_dout",  32'(s_dout),  32'(s_dout_exp));
    check("fw_level",  32'(f_level), 32'(fn));
    check("fw_full",   32'(f_full),  32'(fn == DEPTH));
    check("fw_empty",  32'(f_empty), 32'(fn == 0));
    check("fw_afull",  32'(f_af),    32'(fn >= int'(afull_thresh)));
    check("fw_aempty", 32'(f_ae),    32'(fn <= int'(aempty_thresh)));
    check("fw_ovf",    32'(f_ovf),   32'(f_ovf_exp));
    check("fw_unf",    32'(f_unf),   32'(f_unf_exp));
    check("fw_dvalid", 32'(f_dv),    32'(fn > 0));
    if (fn > 0)
      check("fw_dout", 32'(f_dout), 32'(fq[0]));
  endtask

  task automatic model_reset();
    sq.delete();
    fq.delete();
    s_dout_exp = '0;
    s_dv_exp   = 1'b0;
    s_ovf_exp  = 1'b0;
    s_unf_exp  = 1'b0;
    f_ovf_exp  = 1'b0;
    f_unf_exp  = 1'b0;
  endtask

  // Predict the effect of the current inputs, take one clock edge, then compare.
  task automatic tick();
    bit sw, sr, fw, fr;
    sw = wr_en && (sq.size() < DEPTH);
    sr = rd_en && (sq.size() > 0);
    fw = wr_en && (fq.size() < DEPTH);
    fr = rd_en && (fq.size() > 0);
    s_ovf_exp = (wr_en && sq.size() == DEPTH) ? 1'b1 : (clr_err ? 1'b0 : s_ovf_exp);
    s_unf_exp = (rd_en && sq.size() == 0)     ? 1'b1 : (clr_err ? 1'b0 : s_unf_exp);
    f_ovf_exp = (wr_en && fq.size() == DEPTH) ? 1'b1 : (clr_err ? 1'b0 : f_ovf_exp);
    f_unf_exp = (rd_en && fq.size() == 0)     ? 1'b1 : (clr_err ? 1'b0 : f_unf_exp);
    if (sr) s_dout_exp = sq.pop_front();
    s_dv_exp = sr;
    if (sw) sq.push_back(din);
    if (fr) void'(fq.pop_front());
    if (fw) fq.push_back(din);
    @(posedge clk);
    #1;
    check_state();
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = '0;
    afull_thresh = '0; aempty_thresh = '0;
    model_reset();
    #12;
    $display("[TB] reset state");
    check_state();

    afull_thresh = 5'd14; aempty_thresh = 5'd2;
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] fill to full");
    wr_en = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      din = DW'(i);
      tick();
    end

    $display("[TB] overflow and clear");
    din = 8'hAA;
    tick();
    wr_en = 1'b0;
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;

    $display("[TB] drain");
    rd_en = 1'b1;
    repeat (DEPTH) tick();

    $display("[TB] underflow");
    tick();
    clr_err = 1'b1;
    tick();
    rd_en = 1'b0;
    tick();
    clr_err = 1'b0;

    $display("[TB] level 8 streaming with wrap");
    wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = 8'h20 + DW'(i);
      tick();
    end
    rd_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din = 8'h40 + DW'(i);
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b0;

    $display("[TB] live thresholds");
    afull_thresh = 5'd8; aempty_thresh = 5'd8;
    #1; check_state();
    afull_thresh = 5'd9; aempty_thresh = 5'd7;
    #1; check_state();
    afull_thresh = 5'd31; aempty_thresh = 5'd31;
    #1; check_state();
    afull_thresh = 5'd14; aempty_thresh = 5'd2;

    rd_en = 1'b1;
    repeat (3) tick();
    rd_en = 1'b0;

    $display("[TB] reset mid-stream");
    rst_n = 1'b0;
    #2;
    model_reset();
    check_state();
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] fall-through and back-to-back reads");
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = 8'h55 + DW'(i);
      tick();
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    repeat (4) tick();
    rd_en = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
